frac_serial_tx: RTL and testbench
=================================

FRAC_SERIAL_TX -- requirements
Module: frac_serial_tx

Interface
REQ-001 Parameter CLK_HZ, default 24000000, system clock frequency in Hz.
REQ-002 Parameter OUT_HZ, default 38400, serial bit rate in Hz.
REQ-003 Parameter FRAC_BITS, default 16, phase accumulator width.
REQ-004 Parameter PARITY, default 0, parity mode: 0 none, 1 even, 2 odd.
REQ-005 Parameter STOP_BITS, default 1, stop bit count: 1 or 2.
REQ-006 clk_i  input  1  system clock; all logic on its rising edge; one clock domain.
REQ-007 rst_i  input  1  reset; synchronous and active-high.
REQ-008 clr_i  input  1  synchronous clear; same effect as rst_i; rst_i has priority.
REQ-009 dat_i  input  8  byte to transmit; sampled only on accept.
REQ-010 vld_i  input  1  dat_i valid; upstream holds dat_i and vld_i until accepted.
REQ-011 rdy_o  output 1  holding register empty; a byte is accepted on a cycle with vld_i and rdy_o both high.
REQ-012 sd_o   output 1  serial NRZ data out, registered; idle level 1.
REQ-013 stb_o  output 1  one-cycle pulse at the end of each transmitted bit.
REQ-014 busy_o output 1  high while a frame is in progress or the holding register is full.

Function
REQ-015 INC SHALL equal floor(OUT_HZ * 2^FRAC_BITS / CLK_HZ); elaboration SHALL fail unless 1 <= INC < 2^(FRAC_BITS-1).
REQ-016 Accumulator: FRAC_BITS wide; each cycle outside IDLE acc <= (acc + INC) mod 2^FRAC_BITS; tick = carry out of that addition.
REQ-017 acc SHALL be zeroed on IDLE->START; on STOP->START it SHALL keep running.
REQ-018 Holding register: one byte deep; accept sets hold_full; rdy_o = !hold_full.
REQ-019 The FSM loading the byte into the shift register clears hold_full; rdy_o rises the following cycle; no accept on the unload cycle.
REQ-020 FSM states: IDLE, START, DATA, PAR, STOP.
REQ-021 IDLE: sd_o=1; if hold_full, load the shift register, clear acc, go to START.
REQ-022 START: sd_o=0; on tick, go to DATA with bit index 0.
REQ-023 DATA: sd_o = current bit, LSB first; on tick, shift; on the tick of bit 7, go to PAR if PARITY!=0, else STOP.
REQ-024 PAR: sd_o = XOR of the 8 data bits (even) or its inverse (odd); on tick, go to STOP.
REQ-025 STOP: sd_o=1 for STOP_BITS ticks; on the final tick, go to START if hold_full and load the byte (no idle cycle); otherwise go to IDLE.
REQ-026 Latency: accept at edge N; sd_o SHALL be low from edge N+2.
REQ-027 stb_o SHALL pulse on every tick outside IDLE, and never in IDLE.
REQ-028 busy_o = (state != IDLE) | hold_full.
REQ-029 vld_i while rdy_o is low SHALL be ignored; dat_i is not sampled.
REQ-030 clr_i or rst_i mid-frame SHALL abort the frame, discard the held byte, and apply reset values on the next edge.

Reset
REQ-031 After rst_i or clr_i: state=IDLE, acc=0, hold_full=0, sd_o=1, rdy_o=1, stb_o=0, busy_o=0.
REQ-032 X on dat_i SHALL NOT propagate to sd_o while no byte is being accepted.

Verification
REQ-033 CLK_HZ=16, OUT_HZ=1, FRAC_BITS=16 (INC=4096), PARITY=0, STOP_BITS=1; send 0x55 -> sd_o = 0,1,0,1,0,1,0,1,0,1, each bit exactly 16 cycles; 10 stb_o pulses; busy_o low after the 10th.
REQ-034 Default parameters (INC=104); send 0x00 -> k-th stb_o at cycle ceil(k*65536/104) after the start bit begins; 10th stb_o at cycle 6302.
REQ-035 Back-to-back: send 0xA5, then present 0x3C during the first frame -> rdy_o low from acceptance until the second load; the start bit of 0x3C follows the stop bit of 0xA5 with zero idle cycles.
REQ-036 PARITY=1 with 0x07 -> parity bit 1; PARITY=2 with 0x07 -> parity bit 0; STOP_BITS=2 -> two stop bit periods at 1.
REQ-037 Pulse clr_i during DATA bit 3 with a byte held -> next edge sd_o=1, rdy_o=1, busy_o=0; no further stb_o; the held byte is never sent.
REQ-038 Hold vld_i high with rdy_o low for 50 cycles while changing dat_i -> only the value present at accept is transmitted.

Source files
------------

// File: rtl/frac_serial_tx.sv
// Byte-wide serial NRZ transmitter whose bit timing comes from a fractional phase
// accumulator, with a one-byte holding register so frames can run back to back.
module frac_serial_tx #(
   parameter int CLK_HZ    = 24000000,
   parameter int OUT_HZ    = 38400,
   parameter int FRAC_BITS = 16,
   parameter int PARITY    = 0,
   parameter int STOP_BITS = 1
) (
   input  logic       clk_i,
   input  logic       rst_i,
   input  logic       clr_i,
   input  logic [7:0] dat_i,
   input  logic       vld_i,
   output logic       rdy_o,
   output logic       sd_o,
   output logic       stb_o,
   output logic       busy_o
);

   localparam logic [63:0] INC_W = (64'(OUT_HZ) << FRAC_BITS) / 64'(CLK_HZ);
   localparam logic [FRAC_BITS-1:0] INC = INC_W[FRAC_BITS-1:0];
   localparam logic ODD = (PARITY == 2);

   generate
      if ((INC_W < 64'd1) || (INC_W >= (64'd1 << (FRAC_BITS - 1)))) begin : g_bad_inc
         $error("frac_serial_tx: phase increment out of range");
      end
      if ((PARITY < 0) || (PARITY > 2)) begin : g_bad_parity
         $error("frac_serial_tx: PARITY must be 0, 1 or 2");
      end
      if ((STOP_BITS != 1) && (STOP_BITS != 2)) begin : g_bad_stop
         $error("frac_serial_tx: STOP_BITS must be 1 or 2");
      end
   endgenerate

   typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_PAR, S_STOP} state_t;

   state_t               state_reg, state_next;
   logic [FRAC_BITS-1:0] acc_reg, acc_next;
   logic [7:0]           hold_reg;
   logic                 hold_full_reg, hold_full_next;
   logic [7:0]           shift_reg, shift_next;
   logic [2:0]           bit_cnt_reg, bit_cnt_next;
   logic                 stop_cnt_reg, stop_cnt_next;
   logic                 par_reg;
   logic                 sd_reg, sd_cur;
   logic                 stb_reg;
   logic                 load;
   logic                 accept;
   logic                 tick;
   logic [FRAC_BITS:0]   sum;

   assign sum    = {1'b0, acc_reg} + {1'b0, INC};
   assign tick   = (state_reg != S_IDLE) && sum[FRAC_BITS];
   assign accept = vld_i && !hold_full_reg;

   always_comb begin
      state_next     = state_reg;
      acc_next       = (state_reg != S_IDLE) ? sum[FRAC_BITS-1:0] : acc_reg;
      shift_next     = shift_reg;
      bit_cnt_next   = bit_cnt_reg;
      stop_cnt_next  = stop_cnt_reg;
      load           = 1'b0;
      sd_cur         = 1'b1;
      case (state_reg)
         S_IDLE: begin
            if (hold_full_reg) begin
               load       = 1'b1;
               acc_next   = '0;
               state_next = S_START;
            end
         end
         S_START: begin
            sd_cur = 1'b0;
            if (tick) begin
               bit_cnt_next = 3'd0;
               state_next   = S_DATA;
            end
         end
         S_DATA: begin
            sd_cur = shift_reg[0];
            if (tick) begin
               shift_next   = {1'b0, shift_reg[7:1]};
               bit_cnt_next = bit_cnt_reg + 3'd1;
               if (bit_cnt_reg == 3'd7) begin
                  stop_cnt_next = 1'b0;
                  state_next    = (PARITY != 0) ? S_PAR : S_STOP;
               end
            end
         end
         S_PAR: begin
            sd_cur = par_reg ^ ODD;
            if (tick) begin
               stop_cnt_next = 1'b0;
               state_next    = S_STOP;
            end
         end
         S_STOP: begin
            if (tick) begin
               if (stop_cnt_reg == 1'(STOP_BITS - 1)) begin
                  // Phase keeps running into the next start bit for seamless frames.
                  if (hold_full_reg) begin
                     load       = 1'b1;
                     state_next = S_START;
                  end else begin
                     state_next = S_IDLE;
                  end
               end else begin
                  stop_cnt_next = stop_cnt_reg + 1'b1;
               end
            end
         end
         default: state_next = S_IDLE;
      endcase
      if (load) begin
         shift_next = hold_reg;
      end
      hold_full_next = load ? 1'b0 : (accept ? 1'b1 : hold_full_reg);
   end

   always_ff @(posedge clk_i) begin
      if (rst_i || clr_i) begin
         state_reg     <= S_IDLE;
         acc_reg       <= '0;
         hold_reg      <= '0;
         hold_full_reg <= 1'b0;
         shift_reg     <= '0;
         bit_cnt_reg   <= '0;
         stop_cnt_reg  <= 1'b0;
         par_reg       <= 1'b0;
         sd_reg        <= 1'b1;
         stb_reg       <= 1'b0;
      end else begin
         state_reg     <= state_next;
         acc_reg       <= acc_next;
         hold_full_reg <= hold_full_next;
         shift_reg     <= shift_next;
         bit_cnt_reg   <= bit_cnt_next;
         stop_cnt_reg  <= stop_cnt_next;
         sd_reg        <= sd_cur;
         stb_reg       <= tick;
         if (accept) begin
            hold_reg <= dat_i;
         end
         if (load) begin
            par_reg <= ^hold_reg;
         end
      end
   end

   assign rdy_o  = !hold_full_reg;
   assign sd_o   = sd_reg;
   assign stb_o  = stb_reg;
   assign busy_o = (state_reg != S_IDLE) || hold_full_reg;

endmodule

// File: tb/tb_frac_serial_tx.sv
// Bench for frac_serial_tx: four parameterisations, table vectors, random frames
// against an arithmetic timing model, plus clear and held-valid sequences.
module tb_frac_serial_tx;

   localparam int N_U = 4;
   localparam int CLK_T  [N_U] = '{16, 16, 16, 24000000};
   localparam int OUT_T  [N_U] = '{1, 1, 1, 38400};
   localparam int PAR_T  [N_U] = '{0, 1, 2, 0};
   localparam int STOP_T [N_U] = '{1, 1, 2, 1};
   localparam longint M = 65536;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic           rst;
   logic [N_U-1:0] clr, vld, rdy, sd, stb, busy;
   logic [7:0]     dat [N_U];

   generate
      for (genvar gi = 0; gi < N_U; gi++) begin : g_dut
         frac_serial_tx #(
            .CLK_HZ(CLK_T[gi]), .OUT_HZ(OUT_T[gi]), .FRAC_BITS(16),
            .PARITY(PAR_T[gi]), .STOP_BITS(STOP_T[gi])
         ) u_dut (
            .clk_i(clk), .rst_i(rst), .clr_i(clr[gi]), .dat_i(dat[gi]),
            .vld_i(vld[gi]), .rdy_o(rdy[gi]), .sd_o(sd[gi]),
            .stb_o(stb[gi]), .busy_o(busy[gi])
         );
      end
   endgenerate

   int n_tests = 0;
   int n_fail  = 0;

   task automatic chk(string name, logic [63:0] act, logic [63:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0d, want %0d", name, act, exp);
      end
   endtask

   function automatic longint inc_of(int u);
      return (longint'(OUT_T[u]) * M) / longint'(CLK_T[u]);
   endfunction

   // Frame bits in transmission order (bit 0 first) built from the line format rules.
   function automatic int build_frame(int u, logic [7:0] d, output logic [11:0] bits);
      int n;
      bits = '1;
      bits[0] = 1'b0;
      for (int i = 0; i < 8; i++) bits[1 + i] = d[i];
      n = 9;
      if (PAR_T[u] != 0) begin
         bits[n] = (^d) ^ (PAR_T[u] == 2);
         n++;
      end
      return n + STOP_T[u];
   endfunction

   task automatic wait_rdy(int u, string tag);
      int w = 0;
      while (rdy[u] !== 1'b1 && w < 300) begin
         @(negedge clk);
         w++;
      end
      chk({tag, "_rdy_wait"}, 64'(rdy[u]), 64'd1);
   endtask

   // Sends one or two bytes and checks sd/stb/busy cycle by cycle against the model:
   // in cycle t (t=1 is the first start-bit cycle) the line carries bit floor((t-1)*INC/2^16),
   // and a strobe fires whenever floor(t*INC/2^16) advances.
   task automatic check_stream(int u, logic [7:0] b0, logic [7:0] b1, bit two,
                               logic [23:0] bits, int nbits, int n1, int exp_last, string tag);
      longint inc;
      longint bi;
      int     tt;
      int     sd_err, stb_err, busy_err, first_bad, n_stb, last_stb, rdy_rise;
      logic   e_sd, e_stb, e_busy;
      inc = inc_of(u);
      tt = int'((longint'(nbits) * M + inc - 1) / inc);
      sd_err = 0; stb_err = 0; busy_err = 0; first_bad = 0;
      n_stb = 0; last_stb = 0; rdy_rise = 0;
      wait_rdy(u, tag);
      vld[u] = 1'b1;
      dat[u] = b0;
      @(negedge clk);
      chk({tag, "_rdy_after_accept"}, 64'(rdy[u]), 64'd0);
      chk({tag, "_busy_after_accept"}, 64'(busy[u]), 64'd1);
      if (two) dat[u] = b1;
      else begin
         vld[u] = 1'b0;
         dat[u] = 'x;
      end
      @(negedge clk);
      chk({tag, "_sd_before_start"}, 64'(sd[u]), 64'd1);
      if (two) chk({tag, "_rdy_after_load"}, 64'(rdy[u]), 64'd1);
      for (int t = 1; t <= tt + 3; t++) begin
         @(negedge clk);
         if (t == 1 && two) begin
            vld[u] = 1'b0;
            dat[u] = 'x;
         end
         bi     = (longint'(t - 1) * inc) / M;
         e_sd   = (t <= tt) ? bits[bi] : 1'b1;
         e_stb  = (t <= tt) && (((longint'(t) * inc) / M) > bi);
         e_busy = (t < tt);
         if (sd[u] !== e_sd || stb[u] !== e_stb || busy[u] !== e_busy) begin
            if (first_bad == 0) first_bad = t;
         end
         if (sd[u] !== e_sd) sd_err++;
         if (stb[u] !== e_stb) stb_err++;
         if (busy[u] !== e_busy) busy_err++;
         if (stb[u] === 1'b1) begin
            n_stb++;
            last_stb = t;
         end
         if (two && rdy_rise == 0 && rdy[u] === 1'b1) rdy_rise = t;
      end
      chk($sformatf("%s_sd_wave(first_bad_t=%0d)", tag, first_bad), 64'(sd_err), 64'd0);
      chk({tag, "_stb_wave"}, 64'(stb_err), 64'd0);
      chk({tag, "_busy_wave"}, 64'(busy_err), 64'd0);
      chk({tag, "_stb_count"}, 64'(n_stb), 64'(nbits));
      chk({tag, "_last_stb_cycle"}, 64'(last_stb), 64'(exp_last));
      if (two) chk({tag, "_rdy_rise_cycle"}, 64'(rdy_rise),
                   64'((longint'(n1) * M + inc - 1) / inc));
      $display("[TB] %s unit %0d bytes %02h/%02h two=%0d bits=%0d", tag, u, b0, b1, two, nbits);
   endtask

   typedef struct {
      int          u;
      logic [7:0]  d0;
      logic [7:0]  d1;
      bit          two;
      int          nbits;
      int          n1;
      logic [23:0] bits;
      int          last;
   } vec_t;

   vec_t tbl [8];
   logic samp [1:520];

   initial begin
      logic [11:0] f0, f1;
      logic [23:0] sb;
      logic [7:0]  r0, r1, got;
      int          ru, n0, nb1, rtwo, rdy_hi, t70_busy;
      int          stb_seen, sd_low, busy_seen;
      bit          pend;

      tbl[0] = '{0, 8'h55, 8'h00, 1'b0, 10, 10, 24'({1'b1, 8'h55, 1'b0}), 160};
      tbl[1] = '{1, 8'h07, 8'h00, 1'b0, 11, 11, 24'({1'b1, 1'b1, 8'h07, 1'b0}), 176};
      tbl[2] = '{2, 8'h07, 8'h00, 1'b0, 12, 12, 24'({2'b11, 1'b0, 8'h07, 1'b0}), 192};
      tbl[3] = '{3, 8'h00, 8'h00, 1'b0, 10, 10, 24'({1'b1, 8'h00, 1'b0}), 6302};
      tbl[4] = '{0, 8'hA5, 8'h3C, 1'b1, 20, 10,
                 24'({1'b1, 8'h3C, 1'b0, 1'b1, 8'hA5, 1'b0}), 320};
      tbl[5] = '{1, 8'hFF, 8'h00, 1'b0, 11, 11, 24'({1'b1, 1'b0, 8'hFF, 1'b0}), 176};
      tbl[6] = '{2, 8'hA5, 8'h00, 1'b0, 12, 12, 24'({2'b11, 1'b1, 8'hA5, 1'b0}), 192};
      tbl[7] = '{2, 8'h80, 8'h01, 1'b1, 24, 12,
                 {2'b11, 1'b0, 8'h01, 1'b0, 2'b11, 1'b0, 8'h80, 1'b0}, 384};

      rst = 1'b1;
      clr = '0;
      vld = '0;
      for (int u = 0; u < N_U; u++) dat[u] = 'x;
      repeat (3) @(negedge clk);
      rst = 1'b0;
      @(negedge clk);
      for (int u = 0; u < N_U; u++) begin
         chk($sformatf("reset_sd_u%0d", u), 64'(sd[u]), 64'd1);
         chk($sformatf("reset_rdy_u%0d", u), 64'(rdy[u]), 64'd1);
         chk($sformatf("reset_stb_u%0d", u), 64'(stb[u]), 64'd0);
         chk($sformatf("reset_busy_u%0d", u), 64'(busy[u]), 64'd0);
      end

      for (int i = 0; i < 8; i++) begin
         check_stream(tbl[i].u, tbl[i].d0, tbl[i].d1, tbl[i].two, tbl[i].bits,
                      tbl[i].nbits, tbl[i].n1, tbl[i].last, $sformatf("vec%0d", i));
      end

      for (int r = 0; r < 6; r++) begin
         ru   = 1 + int'($urandom_range(1));
         r0   = 8'($urandom);
         r1   = 8'($urandom);
         rtwo = int'($urandom_range(1));
         n0   = build_frame(ru, r0, f0);
         nb1  = build_frame(ru, r1, f1);
         sb   = '1;
         for (int i = 0; i < n0; i++) sb[i] = f0[i];
         if (rtwo != 0) for (int i = 0; i < nb1; i++) sb[n0 + i] = f1[i];
         if (rtwo == 0) nb1 = 0;
         check_stream(ru, r0, r1, rtwo != 0, sb, n0 + nb1, n0,
                      int'((longint'(n0 + nb1) * M + inc_of(ru) - 1) / inc_of(ru)),
                      $sformatf("rnd%0d", r));
      end

      // Clear in the middle of data bit 3 while a second byte is held.
      wait_rdy(0, "clr");
      vld[0] = 1'b1;
      dat[0] = 8'h3C;
      @(negedge clk);
      dat[0] = 8'hC3;
      @(negedge clk);
      for (int t = 1; t <= 70; t++) begin
         @(negedge clk);
         if (t == 1) begin
            vld[0] = 1'b0;
            dat[0] = 'x;
         end
      end
      t70_busy = int'(busy[0]);
      chk("clr_busy_before", 64'(t70_busy), 64'd1);
      chk("clr_rdy_before", 64'(rdy[0]), 64'd0);
      clr[0] = 1'b1;
      @(negedge clk);
      clr[0] = 1'b0;
      chk("clr_sd", 64'(sd[0]), 64'd1);
      chk("clr_rdy", 64'(rdy[0]), 64'd1);
      chk("clr_busy", 64'(busy[0]), 64'd0);
      chk("clr_stb", 64'(stb[0]), 64'd0);
      stb_seen = 0; sd_low = 0; busy_seen = 0;
      repeat (400) begin
         @(negedge clk);
         if (stb[0] !== 1'b0) stb_seen++;
         if (sd[0] !== 1'b1) sd_low++;
         if (busy[0] !== 1'b0) busy_seen++;
      end
      chk("clr_no_stb_after", 64'(stb_seen), 64'd0);
      chk("clr_line_idle_after", 64'(sd_low), 64'd0);
      chk("clr_not_busy_after", 64'(busy_seen), 64'd0);
      $display("[TB] clr sequence done");

      // Valid held high for 50 cycles with wandering data while the holding register is full.
      wait_rdy(0, "hold");
      vld[0] = 1'b1;
      dat[0] = 8'h11;
      @(negedge clk);
      dat[0] = 8'h22;
      @(negedge clk);
      rdy_hi = 0;
      pend   = 1'b0;
      for (int t = 1; t <= 520; t++) begin
         @(negedge clk);
         samp[t] = sd[0];
         if (pend) begin
            vld[0] = 1'b0;
            dat[0] = 'x;
            pend   = 1'b0;
         end else if (t > 50 && vld[0] === 1'b1 && rdy[0] === 1'b1) begin
            pend = 1'b1;
         end
         if (t <= 50) begin
            if (rdy[0] !== 1'b0) rdy_hi++;
            dat[0] = (t == 50) ? 8'h9E : 8'($urandom);
         end
      end
      chk("hold_rdy_low_50", 64'(rdy_hi), 64'd0);
      for (int f = 0; f < 3; f++) begin
         chk($sformatf("hold_start_f%0d", f), 64'(samp[16 * (10 * f) + 8]), 64'd0);
         for (int i = 0; i < 8; i++) got[i] = samp[16 * (10 * f + 1 + i) + 8];
         chk($sformatf("hold_byte_f%0d", f), 64'(got),
             (f == 0) ? 64'h11 : ((f == 1) ? 64'h22 : 64'h9E));
         chk($sformatf("hold_stop_f%0d", f), 64'(samp[16 * (10 * f + 9) + 8]), 64'd1);
      end
      chk("hold_idle_after", 64'(samp[500]), 64'd1);
      $display("[TB] hold sequence done");

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
